// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : Instruction-fetch stage of the pipelined LoongArch CPU. Owns the
//            PC and next-PC selection, drives the 1-cycle-latency inst SRAM,
//            and keeps a one-entry buffer so a fetched word survives an ID
//            stall. Taken-branch redirects from ID cancel the wrong-path
//            instruction and fetch the target in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h1c000000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        inst_sram_en,
   output logic [3:0]  inst_sram_we,
   output logic [31:0] inst_sram_addr,
   output logic [31:0] inst_sram_wdata,
   input  logic [31:0] inst_sram_rdata,
   input  logic        ds_allowin,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   output logic        fs_to_ds_valid,
   output logic [31:0] fs_to_ds_pc,
   output logic [31:0] fs_to_ds_inst
);

   logic [31:0] fs_pc_q,     fs_pc_d;
   logic        fs_valid_q,  fs_valid_d;
   logic [31:0] inst_buf_q,  inst_buf_d;
   logic        buf_valid_q, buf_valid_d;

   logic        fs_ready_go;
   logic        fs_allowin;
   logic [31:0] seq_pc;
   logic [31:0] nextpc;
   logic        consume;
   logic        capture;

   // The SRAM always answers one cycle after the request, so IF never waits.
   assign fs_ready_go = 1'b1;
   assign fs_allowin  = !fs_valid_q || (fs_ready_go && ds_allowin);

   assign seq_pc = fs_pc_q + 32'd4;
   assign nextpc = br_taken ? br_target : seq_pc;

   // A redirect must fetch its target even while ID is stalled.
   assign inst_sram_en    = !reset && (fs_allowin || br_taken);
   assign inst_sram_addr  = {nextpc[31:2], 2'b00};
   assign inst_sram_we    = 4'b0000;
   assign inst_sram_wdata = 32'b0;

   assign fs_to_ds_valid = !reset && fs_valid_q && fs_ready_go && !br_taken;
   assign fs_to_ds_pc    = fs_pc_q;
   // SRAM data is only trustworthy the cycle after a request; later on the
   // buffered copy is used.
   assign fs_to_ds_inst  = buf_valid_q ? inst_buf_q : inst_sram_rdata;

   assign consume = fs_valid_q && ds_allowin && !br_taken;
   assign capture = fs_valid_q && !buf_valid_q && !ds_allowin && !br_taken;

   // Next-state: PC/valid advance on each request; buffer fills on the first
   // stalled cycle and empties on consumption or redirect.
   always_comb begin
      fs_pc_d     = fs_pc_q;
      fs_valid_d  = fs_valid_q;
      inst_buf_d  = inst_buf_q;
      buf_valid_d = buf_valid_q;

      if (inst_sram_en) begin
         fs_pc_d    = nextpc;
         fs_valid_d = 1'b1;
      end else if (consume) begin
         fs_valid_d = 1'b0;
      end

      if (br_taken || consume) begin
         buf_valid_d = 1'b0;
      end else if (capture) begin
         inst_buf_d  = inst_sram_rdata;
         buf_valid_d = 1'b1;
      end
   end

   // State registers with synchronous reset; PC starts one word before the
   // first fetch so the sequential increment lands on RESET_PC.
   always_ff @(posedge clk) begin
      if (reset) begin
         fs_pc_q     <= RESET_PC - 32'd4;
         fs_valid_q  <= 1'b0;
         inst_buf_q  <= 32'b0;
         buf_valid_q <= 1'b0;
      end else begin
         fs_pc_q     <= fs_pc_d;
         fs_valid_q  <= fs_valid_d;
         inst_buf_q  <= inst_buf_d;
         buf_valid_q <= buf_valid_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Self-checking bench for fetch_stage: directed scenarios followed
//            by randomized handshake/redirect/reset traffic, compared against
//            a behavioural model of the fetch stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

   localparam logic [31:0] RESET_PC = 32'h1c000000;

   logic        clk = 1'b0;
   logic        reset;
   logic        inst_sram_en;
   logic [3:0]  inst_sram_we;
   logic [31:0] inst_sram_addr;
   logic [31:0] inst_sram_wdata;
   logic [31:0] inst_sram_rdata = 32'hdeadbeef;
   logic        ds_allowin;
   logic        br_taken;
   logic [31:0] br_target;
   logic        fs_to_ds_valid;
   logic [31:0] fs_to_ds_pc;
   logic [31:0] fs_to_ds_inst;

   int vectors     = 0;
   int miscompares = 0;

   // Model: whether IF holds an instruction, and its PC.
   bit          m_valid;
   logic [31:0] m_pc;

   always #5 clk = ~clk;

   fetch_stage #(.RESET_PC(RESET_PC)) dut (
      .clk             (clk),
      .reset           (reset),
      .inst_sram_en    (inst_sram_en),
      .inst_sram_we    (inst_sram_we),
      .inst_sram_addr  (inst_sram_addr),
      .inst_sram_wdata (inst_sram_wdata),
      .inst_sram_rdata (inst_sram_rdata),
      .ds_allowin      (ds_allowin),
      .br_taken        (br_taken),
      .br_target       (br_target),
      .fs_to_ds_valid  (fs_to_ds_valid),
      .fs_to_ds_pc     (fs_to_ds_pc),
      .fs_to_ds_inst   (fs_to_ds_inst)
   );

   // Instruction memory contents: a few fixed words, hashed elsewhere.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h1c000000: return 32'h02800405;
         32'h1c000004: return 32'h0280080c;
         32'h1c000008: return 32'h15000001;
         default:      return (a * 32'h9e3779b1) ^ 32'h01234567;
      endcase
   endfunction

   // SRAM model: data only valid the cycle after a request, junk otherwise.
   always @(posedge clk)
      inst_sram_rdata <= inst_sram_en ? mem_word(inst_sram_addr) : 32'hdeadbeef;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Apply one cycle of inputs, check outputs mid-cycle, advance the model.
   task automatic step(input bit rst, input bit ds, input bit br, input logic [31:0] tgt);
      bit          e_en;
      logic [31:0] e_next;
      reset      = rst;
      ds_allowin = ds;
      br_taken   = br;
      br_target  = tgt;
      #1;
      e_en   = !rst && (!m_valid || ds || br);
      e_next = br ? tgt : m_pc + 32'd4;
      check("en",    {31'b0, inst_sram_en},   {31'b0, e_en});
      check("we",    {28'b0, inst_sram_we},   32'b0);
      check("wdata", inst_sram_wdata,         32'b0);
      check("valid", {31'b0, fs_to_ds_valid}, {31'b0, m_valid && !br && !rst});
      if (e_en)
         check("addr", inst_sram_addr, {e_next[31:2], 2'b00});
      if (m_valid && !br && !rst) begin
         check("pc",   fs_to_ds_pc,   m_pc);
         check("inst", fs_to_ds_inst, mem_word({m_pc[31:2], 2'b00}));
      end
      @(posedge clk);
      if (rst) begin
         m_valid = 1'b0;
         m_pc    = RESET_PC - 32'd4;
      end else if (e_en) begin
         m_valid = 1'b1;
         m_pc    = e_next;
      end
      #1;
   endtask

   initial begin
      m_valid = 1'b0;
      m_pc    = RESET_PC - 32'd4;

      // Reset held, then sequential fetch from RESET_PC.
      repeat (3) step(1, 1, 0, 32'h0);
      step(0, 1, 0, 32'h0);               // addr 1c000000
      step(0, 1, 0, 32'h0);               // deliver 1c000000
      step(0, 1, 0, 32'h0);               // deliver 1c000004, IF gets 1c000008
      // Stall at 1c000008 for 3 cycles; SRAM output turns to junk meanwhile.
      repeat (3) step(0, 0, 0, 32'h0);
      step(0, 1, 0, 32'h0);               // deliver 1c000008, request 1c00000c
      step(0, 1, 0, 32'h0);               // IF gets 1c000010
      step(0, 1, 1, 32'h1c000100);        // redirect, 1c000010 dropped
      step(0, 1, 0, 32'h0);               // deliver 1c000100
      // Stall so the buffer fills, then redirect while still stalled.
      repeat (2) step(0, 0, 0, 32'h0);
      step(0, 0, 1, 32'h1c000200);
      step(0, 1, 0, 32'h0);               // deliver 1c000200 from SRAM
      // Unaligned target: aligned address, raw PC held.
      step(0, 1, 1, 32'h1c000123);
      step(0, 1, 0, 32'h0);
      step(0, 1, 0, 32'h0);
      // Wraparound of sequential PC.
      step(0, 1, 1, 32'hfffffffc);
      step(0, 1, 0, 32'h0);
      step(0, 1, 0, 32'h0);
      // Reset mid-stream with a buffered instruction.
      step(0, 1, 1, 32'h1c000040);
      repeat (2) step(0, 0, 0, 32'h0);
      step(1, 0, 0, 32'h0);
      step(0, 1, 0, 32'h0);               // refetch from RESET_PC
      step(0, 1, 0, 32'h0);
      step(0, 1, 0, 32'h0);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] t;
         t = RESET_PC | ($urandom & 32'h0000ffff);
         step(($urandom_range(63) == 0),
              ($urandom_range(3) != 0),
              ($urandom_range(7) == 0),
              t);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
